rank_filter_pipe: RTL
=====================

# rank_filter_pipe

Parametrised, fully pipelined rank-order filter for the median-filter datapath. Accepts one window of N samples per clock, sorts it through an N-layer odd-even transposition network, and returns the element of a per-sample requested rank (median by default) plus the full sorted vector. Replaces the fixed 9×8-bit median sorter and sits between the window/line-buffer stage and the pixel output stage.

## Interface
- WIDTH, 8: bits per sample.
- N, 9: window size; odd, 3..25.
- SIGNED, 0: 1 = compare samples as two's complement, 0 = unsigned.
- RW, $clog2(N): width of the rank port (derived; not overridden).

- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  pipeline advance enable; 0 freezes every stage.
- in_valid  in  1  in_data/in_rank hold a window this cycle.
- in_data  in  N*WIDTH  window; element i at [i*WIDTH +: WIDTH].
- in_rank  in  RW  requested rank, 0 = smallest, (N-1)/2 = median.
- out_valid  out  1  out_* hold a result.
- out_data  out  WIDTH  element of requested rank.
- out_sorted  out  N*WIDTH  ascending sorted window, element 0 smallest.
- out_rank_sat  out  1  in_rank was >= N and was clamped.

## Operation
- Stage 0: on an edge with en=1, register in_data, in_rank and in_valid; if in_rank >= N, store N-1 and set the per-sample saturation flag.
- Stages 1..N: layer j (1-based) compare-exchanges pairs (0,1),(2,3),… when j is odd and (1,2),(3,4),… when j is even; lower value to the lower index. N layers fully sort N elements.
- Output stage: out_data <= sorted[rank]; out_sorted <= sorted vector; out_rank_sat <= flag; out_valid <= stage-N valid.
- Rank, saturation flag and valid travel with their data through every stage; different samples in flight may carry different ranks.
- Comparison is signed or unsigned according to SIGNED; equal elements are not swapped; ordering among equal values is not observable.
- Bubbles (in_valid=0 with en=1) propagate as valid=0 stages; data registers in bubble stages may update but are don't-care.
- en=0: every register, including valid bits and outputs, holds its value. The pipeline state is not lost.
- Reset (rst_n=0 at an edge): all valid bits, out_valid, out_data, out_sorted and out_rank_sat go to 0, regardless of en. In-flight samples are discarded. Reset mid-stream produces no partial outputs afterwards.

## Timing
- Latency: a sample accepted at edge t (en=1, in_valid=1) appears on the outputs after edge t+N+1, with en=1 at every intervening edge. Each en=0 edge adds one cycle.
- Throughput: one window per clock; no backpressure beyond en.
- out_valid is high for exactly one cycle per sample while en=1, and stays high while en=0.
- No combinational path from any input to any output.
- First valid output after reset: not earlier than edge N+1 after rst_n deasserts.

## Structure
- Shared package median_pkg: default WIDTH/N constants and a helper function returning the pair-start offset (0/1) for a layer.
- Sub-module cmp_swap (WIDTH, SIGNED): combinational compare-exchange of two elements, returning lo and hi. Instanced floor(N/2) times per layer through generate loops.
- Top holds the stage registers, valid/rank/flag shift chains, and the output mux.

## Test plan
- N=9, W=8, unsigned: window {9,3,7,1,5,8,2,6,4}, rank 4 -> out_data=5, out_sorted={1..9} ascending, out_valid after edge t+10.
- Same window, ranks 0, 8 and 12 back-to-back on consecutive cycles -> outputs 1, 9, 9 on three consecutive cycles; the third has out_rank_sat=1.
- SIGNED=1: {-3,127,-128,0,5,-1,2,-3,1}, rank 4 -> out_data=0; rank 0 -> -128 (0x80).
- Stream 20 random windows with random in_valid gaps and en held low for 3 cycles mid-stream -> outputs match the software sort model in order, with no drops or duplicates; outputs hold during the stall.
- Assert rst_n=0 for one edge while 5 samples are in flight -> out_valid=0 and all outputs 0 next cycle; no stale sample ever emerges.
- N=3, W=4: {15,0,7}, rank 1 -> out_data=7 after latency 4; all-equal window {6,6,6} -> 6.

Source files
------------

// File: rtl/median_pkg.sv
// median_pkg: shared defaults and layer helper for the rank-order sorter
package median_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_N = 9;
  function automatic int pair_off(input int layer);
    return (layer % 2 == 1) ? 0 : 1;
  endfunction
endpackage

// File: rtl/rank_filter_pipe_if.sv
// rank_filter_pipe_if: window in / ranked result out bundle
interface rank_filter_pipe_if import median_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N = DEF_N,
  parameter int RW = $clog2(N)
);
  logic en;
  logic in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [RW-1:0] in_rank;
  logic out_valid;
  logic [WIDTH-1:0] out_data;
  logic [N*WIDTH-1:0] out_sorted;
  logic out_rank_sat;
  modport master(output en, in_valid, in_data, in_rank,
                 input out_valid, out_data, out_sorted, out_rank_sat);
  modport slave(input en, in_valid, in_data, in_rank,
                output out_valid, out_data, out_sorted, out_rank_sat);
endinterface

// File: rtl/rank_filter_pipe_cmp_swap.sv
// cmp_swap: compare-exchange, smaller value on lo, equal inputs pass straight
module cmp_swap #(
  parameter int WIDTH = 8,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  logic sw;
  // swap only on strict greater-than so equal values never move
  always_comb begin
    sw = (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
    lo = sw ? b : a;
    hi = sw ? a : b;
  end
endmodule

// File: rtl/rank_filter_pipe.sv
// rank_filter_pipe: pipelined odd-even transposition sort with per-sample rank select
module rank_filter_pipe import median_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N = DEF_N,
  parameter int SIGNED = 0,
  parameter int RW = $clog2(N)
) (
  input logic clk,
  input logic rst_n,
  rank_filter_pipe_if.slave bus
);
  logic [WIDTH-1:0] st [0:N][N];
  logic [WIDTH-1:0] nx [1:N][N];
  logic [RW-1:0] rk [0:N];
  logic [N:0] vd;
  logic [N:0] sat;
  logic in_sat;
  assign in_sat = bus.in_rank >= RW'(N);
  for (genvar j = 1; j <= N; j++) begin : g_l
    localparam int O = pair_off(j);
    for (genvar k = 0; k < N; k++) begin : g_e
      if (k >= O && (k - O) % 2 == 0 && k + 1 < N) begin : g_c
        cmp_swap #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cs (
          .a(st[j-1][k]), .b(st[j-1][k+1]), .lo(nx[j][k]), .hi(nx[j][k+1]));
      end else if (!(k >= O + 1 && (k - 1 - O) % 2 == 0)) begin : g_p
        assign nx[j][k] = st[j-1][k];
      end
    end
  end
  // data and rank stages: capture with clamp, then one sort layer per stage
  always_ff @(posedge clk)
    if (bus.en) begin
      for (int i = 0; i < N; i++) st[0][i] <= bus.in_data[i*WIDTH +: WIDTH];
      for (int i = 1; i <= N; i++) st[i] <= nx[i];
      rk[0] <= in_sat ? RW'(N - 1) : bus.in_rank;
      for (int i = 1; i <= N; i++) rk[i] <= rk[i-1];
    end
  // valid and saturation chains travel alongside the data
  always_ff @(posedge clk)
    if (!rst_n) begin
      vd <= '0;
      sat <= '0;
    end else if (bus.en) begin
      vd <= {vd[N-1:0], bus.in_valid};
      sat <= {sat[N-1:0], in_sat};
    end
  // output stage: rank mux and sorted vector
  always_ff @(posedge clk)
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_sorted <= '0;
      bus.out_rank_sat <= 1'b0;
    end else if (bus.en) begin
      bus.out_valid <= vd[N];
      bus.out_data <= st[N][rk[N]];
      bus.out_rank_sat <= sat[N];
      for (int i = 0; i < N; i++) bus.out_sorted[i*WIDTH +: WIDTH] <= st[N][i];
    end
endmodule
